// File: rtl/riscv_int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_int_pkg
//  Description : Shared definitions for the machine-level interrupt
//                controller: mcause codes, mip bit positions, register
//                offsets and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_int_pkg;

    // mcause exception codes (interrupt bit is added by the trap unit)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mip / mie bit positions
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // Register select, taken from addr[3:2]
    typedef enum logic [1:0] {
        REG_MSIP     = 2'd0,
        REG_EXT_PEND = 2'd1,
        REG_EXT_EN   = 2'd2,
        REG_EXT_EDGE = 2'd3
    } riscv_int_reg_e;

    // Trap-request FSM
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } riscv_int_state_e;

endpackage : riscv_int_pkg
`default_nettype wire

// File: rtl/mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_if
//  Description : Simple peripheral register bus. Master issues req/we/addr/
//                wdata; slave returns ready and a registered rdata qualified
//                by valid.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        valid;

    modport master (output req, we, addr, wdata, input rdata, ready, valid);
    modport slave  (input req, we, addr, wdata, output rdata, ready, valid);
endinterface : mem_if
`default_nettype wire

// File: rtl/riscv_int_sync.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_int_sync
//  Description : Multi-flop synchroniser for one asynchronous input.
//  Ports       : i_clk    core clock
//                i_rst_n  synchronous reset, active-low
//                i_d      asynchronous input
//                o_q      synchronised output (SYNC_STAGES cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[SYNC_STAGES-1];

endmodule : riscv_int_sync
`default_nettype wire

// File: rtl/riscv_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_int_ctrl
//  Description : Machine-level interrupt aggregator. Combines MTIP from the
//                machine timer, a memory-mapped MSIP bit and NUM_EXT external
//                lines into the mip view and a prioritised trap request
//                (MEI > MSI > MTI) with a req/ack handshake.
//  Ports       : i_clk, i_rst_n   clock, synchronous active-low reset
//                i_timer_int      MTIP level (same clock domain)
//                i_ext_int        asynchronous external lines
//                i_mstatus_mie    global machine interrupt enable
//                i_mie            mie CSR (bits 3, 7, 11)
//                i_irq_ack        core has taken the trap
//                o_irq_req        registered trap request
//                o_irq_cause      latched mcause code
//                o_mip            registered mip view
//                if_mem           register-access slave port
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_int_ctrl
    import riscv_int_pkg::*;
#(
    parameter int NUM_EXT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_timer_int,
    input  logic [NUM_EXT-1:0] i_ext_int,
    input  logic               i_mstatus_mie,
    input  logic [31:0]        i_mie,
    input  logic               i_irq_ack,
    output logic               o_irq_req,
    output logic [3:0]         o_irq_cause,
    output logic [31:0]        o_mip,
    mem_if.slave               if_mem
);

    // ------------------------------------------------------------------
    // External line synchronisation and edge detection
    // ------------------------------------------------------------------
    logic [NUM_EXT-1:0] w_sync;
    logic [NUM_EXT-1:0] r_prev;
    logic [NUM_EXT-1:0] w_rise;

    for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
        riscv_int_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_ext_int[g]),
            .o_q     (w_sync[g])
        );
    end

    assign w_rise = w_sync & ~r_prev;

    // ------------------------------------------------------------------
    // Register interface
    // ------------------------------------------------------------------
    logic               r_msip;
    logic [NUM_EXT-1:0] r_en;
    logic [NUM_EXT-1:0] r_edge;
    logic [NUM_EXT-1:0] r_sticky;
    logic [31:0]        r_data;
    logic               r_valid;

    riscv_int_reg_e     w_addr;
    logic               w_wr;
    logic               w_rd;
    logic [NUM_EXT-1:0] w_wdata;
    logic [NUM_EXT-1:0] w_w1c;
    logic [NUM_EXT-1:0] w_mode_chg;
    logic [NUM_EXT-1:0] w_pending;
    logic [31:0]        w_rdata;

    assign w_addr  = riscv_int_reg_e'(if_mem.addr[3:2]);
    assign w_wr    = if_mem.req &  if_mem.we;
    assign w_rd    = if_mem.req & ~if_mem.we;
    assign w_wdata = if_mem.wdata[NUM_EXT-1:0];

    // Edge-mode lines report their sticky bit, level-mode lines the synced level
    assign w_pending  = (r_edge & r_sticky) | (~r_edge & w_sync);
    assign w_w1c      = (w_wr && w_addr == REG_EXT_PEND) ? w_wdata : '0;
    assign w_mode_chg = (w_wr && w_addr == REG_EXT_EDGE) ? (w_wdata ^ r_edge) : '0;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_MSIP:     w_rdata = {31'd0, r_msip};
            REG_EXT_PEND: w_rdata = 32'(w_pending);
            REG_EXT_EN:   w_rdata = 32'(r_en);
            REG_EXT_EDGE: w_rdata = 32'(r_edge);
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_msip   <= 1'b0;
            r_en     <= '0;
            r_edge   <= '0;
            r_sticky <= '0;
            r_prev   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_prev  <= w_sync;
            r_valid <= w_rd;
            if (w_rd) begin
                r_data <= w_rdata;
            end
            if (w_wr && w_addr == REG_MSIP) begin
                r_msip <= if_mem.wdata[0];
            end
            if (w_wr && w_addr == REG_EXT_EN) begin
                r_en <= w_wdata;
            end
            if (w_wr && w_addr == REG_EXT_EDGE) begin
                r_edge <= w_wdata;
            end
            // A rising edge in the same cycle as W1C keeps the bit set;
            // a mode change discards whatever was latched under the old mode.
            r_sticky <= ((r_sticky & ~w_w1c) | w_rise) & r_edge & ~w_mode_chg;
        end
    end

    assign if_mem.ready = 1'b1;
    assign if_mem.rdata = r_data;
    assign if_mem.valid = r_valid;

    // ------------------------------------------------------------------
    // mip view
    // ------------------------------------------------------------------
    logic [31:0] r_mip;
    logic [31:0] w_mip_next;

    always_comb begin
        w_mip_next           = '0;
        w_mip_next[MIP_MSIP] = r_msip;
        w_mip_next[MIP_MTIP] = i_timer_int;
        w_mip_next[MIP_MEIP] = |(w_pending & r_en);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mip <= '0;
        end else begin
            r_mip <= w_mip_next;
        end
    end

    assign o_mip = r_mip;

    // ------------------------------------------------------------------
    // Prioritisation and trap-request FSM
    // ------------------------------------------------------------------
    logic             w_elig_mei;
    logic             w_elig_msi;
    logic             w_elig_mti;
    logic             w_any_elig;
    logic             w_latched_elig;
    logic [3:0]       w_top_cause;
    riscv_int_state_e r_state;
    logic             r_irq_req;
    logic [3:0]       r_irq_cause;

    assign w_elig_mei = i_mstatus_mie & r_mip[MIP_MEIP] & i_mie[MIP_MEIP];
    assign w_elig_msi = i_mstatus_mie & r_mip[MIP_MSIP] & i_mie[MIP_MSIP];
    assign w_elig_mti = i_mstatus_mie & r_mip[MIP_MTIP] & i_mie[MIP_MTIP];
    assign w_any_elig = w_elig_mei | w_elig_msi | w_elig_mti;

    assign w_top_cause = w_elig_mei ? CAUSE_MEI :
                         w_elig_msi ? CAUSE_MSI : CAUSE_MTI;

    always_comb begin
        w_latched_elig = 1'b0;
        case (r_irq_cause)
            CAUSE_MEI: w_latched_elig = w_elig_mei;
            CAUSE_MSI: w_latched_elig = w_elig_msi;
            CAUSE_MTI: w_latched_elig = w_elig_mti;
            default:   w_latched_elig = 1'b0;
        endcase
    end

    // HOLDOFF makes the same decision IDLE would, so the request gap after
    // an ack is exactly the single HOLDOFF cycle; a core that clears
    // mstatus.MIE on trap entry has had that cycle to do so.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_irq_req   <= 1'b0;
            r_irq_cause <= 4'd0;
        end else begin
            case (r_state)
                IDLE, HOLDOFF: begin
                    if (w_any_elig) begin
                        r_state     <= REQ;
                        r_irq_req   <= 1'b1;
                        r_irq_cause <= w_top_cause;
                    end else begin
                        r_state   <= IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                REQ: begin
                    if (i_irq_ack) begin
                        r_state   <= HOLDOFF;
                        r_irq_req <= 1'b0;
                    end else if (!w_latched_elig) begin
                        r_state   <= IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_irq_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_irq_req   = r_irq_req;
    assign o_irq_cause = r_irq_cause;

    // Bits of the CSR and bus words that this block does not decode
    logic w_unused;
    assign w_unused = ^{i_mie, if_mem.addr, if_mem.wdata};

endmodule : riscv_int_ctrl
`default_nettype wire

// File: tb/tb_riscv_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_int_ctrl
//  Description : Directed self-checking bench for riscv_int_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_int_ctrl;

    localparam int NUM_EXT     = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [31:0] A_MSIP = 32'h0;
    localparam logic [31:0] A_PEND = 32'h4;
    localparam logic [31:0] A_EN   = 32'h8;
    localparam logic [31:0] A_EDGE = 32'hC;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               timer_int;
    logic [NUM_EXT-1:0] ext_int;
    logic               mstatus_mie;
    logic [31:0]        mie;
    logic               irq_ack;
    logic               irq_req;
    logic [3:0]         irq_cause;
    logic [31:0]        mip;

    int errors = 0;
    int checks = 0;

    mem_if u_mem ();

    riscv_int_ctrl #(
        .NUM_EXT     (NUM_EXT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_timer_int   (timer_int),
        .i_ext_int     (ext_int),
        .i_mstatus_mie (mstatus_mie),
        .i_mie         (mie),
        .i_irq_ack     (irq_ack),
        .o_irq_req     (irq_req),
        .o_irq_cause   (irq_cause),
        .o_mip         (mip),
        .if_mem        (u_mem)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        u_mem.req   = 1'b1;
        u_mem.we    = 1'b1;
        u_mem.addr  = addr;
        u_mem.wdata = data;
        tick();
        u_mem.req   = 1'b0;
        u_mem.we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        u_mem.req  = 1'b1;
        u_mem.we   = 1'b0;
        u_mem.addr = addr;
        tick();
        data       = u_mem.rdata;
        u_mem.req  = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        // ---------------- 1: reset with every input high ----------------
        rst_n       = 1'b0;
        timer_int   = 1'b1;
        ext_int     = '1;
        mstatus_mie = 1'b1;
        mie         = 32'hFFFF_FFFF;
        irq_ack     = 1'b1;
        u_mem.req   = 1'b1;
        u_mem.we    = 1'b1;
        u_mem.addr  = 32'hFFFF_FFFF;
        u_mem.wdata = 32'hFFFF_FFFF;
        tick(3);
        check("rst_req",   32'(irq_req), 32'd0);
        check("rst_mip",   mip, 32'd0);
        check("rst_cause", 32'(irq_cause), 32'd0);
        check("rst_rdata", u_mem.rdata, 32'd0);

        timer_int   = 1'b0;
        ext_int     = '0;
        mstatus_mie = 1'b0;
        mie         = 32'd0;
        irq_ack     = 1'b0;
        u_mem.req   = 1'b0;
        u_mem.we    = 1'b0;
        u_mem.wdata = 32'd0;
        rst_n       = 1'b1;
        tick(3);
        bus_read(A_MSIP, rd); check("rst_rd_msip", rd, 32'd0);
        check("rd_valid", 32'(u_mem.valid), 32'd1);
        bus_read(A_PEND, rd); check("rst_rd_pend", rd, 32'd0);
        bus_read(A_EN,   rd); check("rst_rd_en",   rd, 32'd0);
        bus_read(A_EDGE, rd); check("rst_rd_edge", rd, 32'd0);

        // ---------------- 2: timer interrupt ----------------
        mie         = 32'h80;
        mstatus_mie = 1'b1;
        timer_int   = 1'b1;
        tick();
        check("tmr_mip",      mip, 32'h80);
        check("tmr_req_late", 32'(irq_req), 32'd0);
        tick();
        check("tmr_req",   32'(irq_req), 32'd1);
        check("tmr_cause", 32'(irq_cause), 32'd7);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("tmr_holdoff", 32'(irq_req), 32'd0);
        tick();
        check("tmr_rereq",   32'(irq_req), 32'd1);
        check("tmr_recause", 32'(irq_cause), 32'd7);
        timer_int = 1'b0;
        tick();
        check("tmr_wd_hold", 32'(irq_req), 32'd1);
        tick();
        check("tmr_wd_drop", 32'(irq_req), 32'd0);

        // ---------------- 3: priority ----------------
        mstatus_mie = 1'b0;
        mie         = 32'h888;
        bus_write(A_EDGE, 32'h1);
        bus_write(A_EN,   32'h1);
        bus_write(A_MSIP, 32'h1);
        timer_int  = 1'b1;
        ext_int[0] = 1'b1;
        tick(4);
        bus_read(A_PEND, rd); check("pri_pend", rd, 32'h1);
        check("pri_mip",   mip, 32'h888);
        check("pri_gated", 32'(irq_req), 32'd0);
        mstatus_mie = 1'b1;
        tick();
        check("pri_req",   32'(irq_req), 32'd1);
        check("pri_cause", 32'(irq_cause), 32'd11);
        bus_write(A_PEND, 32'h1);
        check("pri_w1c_req", 32'(irq_req), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("pri_holdoff", 32'(irq_req), 32'd0);
        tick();
        check("pri_req2",   32'(irq_req), 32'd1);
        check("pri_cause2", 32'(irq_cause), 32'd3);

        // ---------------- 4: withdrawal without ack ----------------
        timer_int = 1'b0;
        bus_write(A_MSIP, 32'h0);
        check("wd_req_k",  32'(irq_req), 32'd1);
        tick();
        check("wd_req_k1", 32'(irq_req), 32'd1);
        tick();
        check("wd_drop",  32'(irq_req), 32'd0);
        check("wd_cause", 32'(irq_cause), 32'd3);
        tick(2);
        check("wd_idle",  32'(irq_req), 32'd0);

        // ---------------- 5: edge / level ----------------
        mstatus_mie = 1'b0;
        ext_int     = '0;
        tick(3);
        bus_write(A_EDGE, 32'h4);
        ext_int[2] = 1'b1; tick(); ext_int[2] = 1'b0;
        bus_read(A_PEND, rd); check("edg_pend_a1", rd, 32'h0);
        bus_read(A_PEND, rd); check("edg_pend_a2", rd, 32'h0);
        bus_read(A_PEND, rd); check("edg_pend_a3", rd, 32'h4);
        tick(3);
        bus_read(A_PEND, rd); check("edg_sticky", rd, 32'h4);
        bus_write(A_PEND, 32'h4);
        bus_read(A_PEND, rd); check("edg_w1c", rd, 32'h0);
        ext_int[2] = 1'b1; tick(); ext_int[2] = 1'b0;
        tick();
        bus_write(A_PEND, 32'h4);           // W1C coincides with the rise
        bus_read(A_PEND, rd); check("edg_set_wins", rd, 32'h4);
        ext_int[1] = 1'b1;
        tick(3);
        bus_read(A_PEND, rd); check("lvl_pend", rd, 32'h6);
        bus_write(A_PEND, 32'h6);
        bus_read(A_PEND, rd); check("lvl_w1c_ign", rd, 32'h2);
        ext_int[2] = 1'b1; tick(); ext_int[2] = 1'b0;
        tick(3);
        bus_read(A_PEND, rd); check("edg_pend_b", rd, 32'h6);
        bus_write(A_EDGE, 32'h0);
        bus_read(A_PEND, rd); check("mode_clr", rd, 32'h2);
        bus_write(A_EDGE, 32'hFFFF_FFFF);
        bus_read(A_EDGE, rd); check("edge_width", rd, 32'hFF);
        bus_write(A_EDGE, 32'h0);
        bus_write(A_EN, 32'hFFFF_FFFF);
        bus_read(A_EN, rd); check("en_width", rd, 32'hFF);
        bus_write(A_MSIP, 32'hFFFF_FFFF);
        bus_read(A_MSIP, rd); check("msip_width", rd, 32'h1);

        // ---------------- 6: global enable gating ----------------
        bus_write(A_EN, 32'h2);
        timer_int = 1'b1;
        mie       = 32'h888;
        tick(4);
        check("gate_mip",   mip, 32'h888);
        check("gate_noreq", 32'(irq_req), 32'd0);
        mstatus_mie = 1'b1;
        for (int i = 0; i < 2 && !irq_req; i++) tick();
        check("gate_req",   32'(irq_req), 32'd1);
        check("gate_cause", 32'(irq_cause), 32'd11);

        // ---------------- reset while requesting ----------------
        rst_n = 1'b0;
        tick();
        check("rst_mid_req", 32'(irq_req), 32'd0);
        check("rst_mid_mip", mip, 32'd0);
        rst_n = 1'b1;
        mstatus_mie = 1'b0;
        bus_read(A_MSIP, rd); check("rst_mid_msip", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_riscv_int_ctrl
`default_nettype wire
